// File: rtl/mrav_timer_if.sv
// Bus-decoder handshake for the mrav timer.
// Master is the decoder/core side, slave is the timer.
interface mrav_timer_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          dev_read;
    logic          dev_write;
    logic [AW-1:0] dev_addr;
    logic [DW-1:0] dev_cpu_data_out;
    logic [DW-1:0] dev_cpu_data_in;
    logic          dev_read_done;
    logic          dev_write_done;

    modport master (
        output dev_read,
        output dev_write,
        output dev_addr,
        output dev_cpu_data_out,
        input  dev_cpu_data_in,
        input  dev_read_done,
        input  dev_write_done
    );

    modport slave (
        input  dev_read,
        input  dev_write,
        input  dev_addr,
        input  dev_cpu_data_out,
        output dev_cpu_data_in,
        output dev_read_done,
        output dev_write_done
    );
endinterface

// File: rtl/mrav_timer.sv
// Memory-mapped prescaled timer with compare match, auto-reload and irq.
// Bus transactions complete one cycle after the request.
module mrav_timer #(
    parameter int MRAV_ADDR_WIDTH = 32,
    parameter int MRAV_DATA_WIDTH = 32,
    parameter logic [MRAV_ADDR_WIDTH-1:0] BASE_ADDR =
        MRAV_ADDR_WIDTH'(32'h0000_1000)
) (
    input  logic clk,
    input  logic rst,
    mrav_timer_if.slave bus,
    output logic irq
);
    localparam int AW = MRAV_ADDR_WIDTH;
    localparam int DW = MRAV_DATA_WIDTH;

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_PRE,
        SEL_CMP,
        SEL_CNT,
        SEL_STAT,
        SEL_NONE
    } sel_e;

    state_e        state_q, state_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [DW-1:0] pre_q, pre_d;
    logic [DW-1:0] cmp_q, cmp_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          match_q, match_d;
    logic [DW-1:0] psc_q, psc_d;

    logic [AW-1:0] off;
    sel_e          sel;
    logic [DW-1:0] rd_val;
    logic          req;
    logic          wr_en;
    logic          tick;
    logic          hit;
    logic          clr;

    assign off = bus.dev_addr - BASE_ADDR;

    always_comb begin
        sel = SEL_NONE;
        case (off)
            AW'(32'h00): sel = SEL_CTRL;
            AW'(32'h04): sel = SEL_PRE;
            AW'(32'h08): sel = SEL_CMP;
            AW'(32'h0C): sel = SEL_CNT;
            AW'(32'h10): sel = SEL_STAT;
            default:     sel = SEL_NONE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            SEL_CTRL: rd_val = {{(DW-3){1'b0}}, ctrl_q};
            SEL_PRE:  rd_val = pre_q;
            SEL_CMP:  rd_val = cmp_q;
            SEL_CNT:  rd_val = cnt_q;
            SEL_STAT: rd_val = {{(DW-1){1'b0}}, match_q};
            default:  rd_val = '0;
        endcase
    end

    assign req   = bus.dev_read | bus.dev_write;
    assign wr_en = (state_q == IDLE) && bus.dev_write;

    // Bus FSM: a write wins over a simultaneous read.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = RESP;
                    wr_d    = bus.dev_write;
                    rdata_d = bus.dev_write ? '0 : rd_val;
                end
            end
            RESP: begin
                state_d = IDLE;
                wr_d    = 1'b0;
                rdata_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tick = ctrl_q[0] && (psc_q == pre_q);
    assign hit  = tick && (cnt_q == cmp_q);
    assign clr  = wr_en && (sel == SEL_STAT) &&
                  bus.dev_cpu_data_out[0];

    // Timer datapath; bus writes are applied last so they win.
    always_comb begin
        ctrl_d  = ctrl_q;
        pre_d   = pre_q;
        cmp_d   = cmp_q;
        cnt_d   = cnt_q;
        psc_d   = psc_q;
        match_d = (match_q && !clr) || hit;

        if (ctrl_q[0]) begin
            psc_d = tick ? '0 : psc_q + DW'(1);
        end
        if (tick) begin
            cnt_d = (hit && ctrl_q[1]) ? '0 : cnt_q + DW'(1);
        end

        if (wr_en) begin
            case (sel)
                SEL_CTRL: begin
                    ctrl_d = bus.dev_cpu_data_out[2:0];
                    if (bus.dev_cpu_data_out[0] && !ctrl_q[0]) begin
                        psc_d = '0;
                    end
                end
                SEL_PRE: begin
                    pre_d = bus.dev_cpu_data_out;
                    psc_d = '0;
                end
                SEL_CMP: cmp_d = bus.dev_cpu_data_out;
                SEL_CNT: cnt_d = bus.dev_cpu_data_out;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ctrl_q  <= '0;
            pre_q   <= '0;
            cmp_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            psc_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ctrl_q  <= ctrl_d;
            pre_q   <= pre_d;
            cmp_q   <= cmp_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            psc_q   <= psc_d;
        end
    end

    // Outputs are forced low while reset is held.
    always_comb begin
        bus.dev_read_done  = 1'b0;
        bus.dev_write_done = 1'b0;
        bus.dev_cpu_data_in = '0;
        if (!rst && state_q == RESP) begin
            bus.dev_read_done   = !wr_q;
            bus.dev_write_done  = wr_q;
            bus.dev_cpu_data_in = wr_q ? '0 : rdata_q;
        end
    end

    assign irq = !rst && match_q && ctrl_q[2];
endmodule

// File: tb/tb_mrav_timer.sv
// Directed bench for mrav_timer: cycle model plus per-scenario
// literal expectations.
module tb_mrav_timer;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PRE  = BASE + 32'h04;
    localparam logic [31:0] A_CMP  = BASE + 32'h08;
    localparam logic [31:0] A_CNT  = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;
    localparam logic [31:0] A_BAD  = BASE + 32'h20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic irq;
    int   checks = 0;
    int   failures = 0;
    bit   chk_on = 1'b0;

    mrav_timer_if #(.AW(32), .DW(32)) bus ();

    mrav_timer #(
        .MRAV_ADDR_WIDTH(32),
        .MRAV_DATA_WIDTH(32),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, exp);
        end
    endtask

    // Behavioural model: registers, timer phase and bus response.
    logic [2:0]  m_ctrl = '0;
    logic [31:0] m_pre = '0;
    logic [31:0] m_cmp = '0;
    logic [31:0] m_cnt = '0;
    logic        m_match = 1'b0;
    int unsigned m_phase = 0;
    logic        m_resp = 1'b0;
    logic        m_wr = 1'b0;
    logic [31:0] m_rdata = '0;

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a - BASE)
            32'h00:  return {29'd0, m_ctrl};
            32'h04:  return m_pre;
            32'h08:  return m_cmp;
            32'h0C:  return m_cnt;
            32'h10:  return {31'd0, m_match};
            default: return 32'd0;
        endcase
    endfunction

    logic [2:0]  n_ctrl;
    logic [31:0] n_pre, n_cmp, n_cnt, wd, rel;
    logic        n_match, tk, is_match, start_wr;
    int unsigned n_phase;

    always @(posedge clk) begin
        if (rst) begin
            m_ctrl <= '0; m_pre <= '0; m_cmp <= '0;
            m_cnt <= '0; m_match <= 1'b0; m_phase <= 0;
            m_resp <= 1'b0; m_wr <= 1'b0; m_rdata <= '0;
        end else begin
            n_ctrl = m_ctrl; n_pre = m_pre; n_cmp = m_cmp;
            n_cnt = m_cnt; n_match = m_match; n_phase = m_phase;
            wd = bus.dev_cpu_data_out;
            rel = bus.dev_addr - BASE;
            tk = m_ctrl[0] && (m_phase == m_pre);
            is_match = tk && (m_cnt == m_cmp);
            if (m_ctrl[0]) n_phase = tk ? 0 : m_phase + 1;
            if (tk) n_cnt = (is_match && m_ctrl[1]) ? 32'd0 : m_cnt + 32'd1;
            start_wr = !m_resp && bus.dev_write;
            if (start_wr) begin
                if (rel == 32'h00) begin
                    n_ctrl = wd[2:0];
                    if (wd[0] && !m_ctrl[0]) n_phase = 0;
                end
                if (rel == 32'h04) begin
                    n_pre = wd;
                    n_phase = 0;
                end
                if (rel == 32'h08) n_cmp = wd;
                if (rel == 32'h0C) n_cnt = wd;
                if (rel == 32'h10 && wd[0]) n_match = 1'b0;
            end
            if (is_match) n_match = 1'b1;
            if (!m_resp && (bus.dev_write || bus.dev_read)) begin
                m_resp <= 1'b1;
                m_wr <= bus.dev_write;
                m_rdata <= bus.dev_write ? 32'd0 : m_read(bus.dev_addr);
            end else begin
                m_resp <= 1'b0;
                m_wr <= 1'b0;
            end
            m_ctrl <= n_ctrl; m_pre <= n_pre; m_cmp <= n_cmp;
            m_cnt <= n_cnt; m_match <= n_match; m_phase <= n_phase;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_wdone", {31'd0, bus.dev_write_done},
                  {31'd0, !rst && m_resp && m_wr});
            check("cyc_rdone", {31'd0, bus.dev_read_done},
                  {31'd0, !rst && m_resp && !m_wr});
            check("cyc_rdata", bus.dev_cpu_data_in,
                  (!rst && m_resp && !m_wr) ? m_rdata : 32'd0);
            check("cyc_irq", {31'd0, irq},
                  {31'd0, !rst && m_match && m_ctrl[2]});
        end
    end

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bus.dev_write = 1'b1;
        bus.dev_addr = a;
        bus.dev_cpu_data_out = d;
        @(posedge clk); #1;
        check("wr_done_latency", {31'd0, bus.dev_write_done}, 32'd1);
        bus.dev_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus.dev_read = 1'b1;
        bus.dev_addr = a;
        @(posedge clk); #1;
        check("rd_done_latency", {31'd0, bus.dev_read_done}, 32'd1);
        d = bus.dev_cpu_data_in;
        bus.dev_read = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] rv, prev;
    int n;
    logic [31:0] addrs [5];

    initial begin
        addrs = '{A_CTRL, A_PRE, A_CMP, A_CNT, A_STAT};
        bus.dev_read = 1'b0;
        bus.dev_write = 1'b0;
        bus.dev_addr = '0;
        bus.dev_cpu_data_out = '0;
        @(posedge clk);
        chk_on = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        foreach (addrs[i]) begin
            bus_rd(addrs[i], rv);
            check("reset_reg", rv, 32'd0);
        end

        // Compare match with irq and auto-reload, prescale 0.
        bus_wr(A_CMP, 32'd5);
        bus_wr(A_PRE, 32'd0);
        bus_wr(A_CTRL, 32'h7);
        n = 1;
        while (!irq && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("irq_after_ticks", n, 32'd6);
        bus_rd(A_CNT, rv);
        check("count_reloaded", rv, 32'd0);
        bus_wr(A_STAT, 32'd1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        bus_wr(A_CTRL, 32'd0);

        // Prescale 3: one tick every 4 cycles.
        bus_wr(A_CMP, 32'hFFFF);
        bus_wr(A_CNT, 32'd0);
        bus_wr(A_PRE, 32'd3);
        bus_wr(A_CTRL, 32'h1);
        repeat (8) @(posedge clk);
        #1;
        bus_rd(A_CNT, rv);
        check("presc3_count", rv, 32'd2);
        prev = rv;
        for (int k = 0; k < 4; k++) begin
            repeat (3) @(posedge clk);
            #1;
            bus_rd(A_CNT, rv);
            check("count_increasing", {31'd0, rv > prev}, 32'd1);
            prev = rv;
        end

        // Wrap from all-ones without match, then match at 0.
        bus_wr(A_CTRL, 32'd0);
        bus_wr(A_STAT, 32'd1);
        bus_wr(A_PRE, 32'd9);
        bus_wr(A_CMP, 32'd0);
        bus_wr(A_CNT, 32'hFFFF_FFFF);
        bus_wr(A_CTRL, 32'h1);
        repeat (11) @(posedge clk);
        #1;
        bus_rd(A_CNT, rv);
        check("wrap_count", rv, 32'd0);
        bus_rd(A_STAT, rv);
        check("wrap_no_match", rv, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        bus_rd(A_CNT, rv);
        check("post_wrap_count", rv, 32'd1);
        bus_rd(A_STAT, rv);
        check("post_wrap_match", rv, 32'd1);
        bus_wr(A_CTRL, 32'd0);
        bus_wr(A_STAT, 32'd1);

        // COUNT write on the same edge as a tick.
        bus_wr(A_PRE, 32'd7);
        bus_wr(A_CMP, 32'hFFFF);
        bus_wr(A_CTRL, 32'h1);
        repeat (6) @(posedge clk);
        #1;
        bus_wr(A_CNT, 32'h10);
        bus_rd(A_CNT, rv);
        check("count_write_wins", rv, 32'h10);
        bus_wr(A_CTRL, 32'd0);

        // Read and write together: write wins.
        bus.dev_read = 1'b1;
        bus.dev_write = 1'b1;
        bus.dev_addr = A_CMP;
        bus.dev_cpu_data_out = 32'h1234;
        @(posedge clk); #1;
        check("both_wdone", {31'd0, bus.dev_write_done}, 32'd1);
        check("both_rdone", {31'd0, bus.dev_read_done}, 32'd0);
        bus.dev_read = 1'b0;
        bus.dev_write = 1'b0;
        @(posedge clk); #1;
        bus_rd(A_CMP, rv);
        check("both_cmp", rv, 32'h1234);
        bus_rd(A_BAD, rv);
        check("unmapped_read", rv, 32'd0);
        bus_wr(A_BAD, 32'hDEAD);
        bus_rd(A_BAD, rv);
        check("unmapped_after_wr", rv, 32'd0);

        // Reset during RESP aborts and clears everything.
        bus_wr(A_CNT, 32'd5);
        bus_wr(A_PRE, 32'd2);
        bus_wr(A_CTRL, 32'h7);
        bus.dev_write = 1'b1;
        bus.dev_addr = A_CMP;
        bus.dev_cpu_data_out = 32'hAAAA;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.dev_write = 1'b0;
        #1;
        check("rst_resp_wdone", {31'd0, bus.dev_write_done}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rst_no_wdone", {31'd0, bus.dev_write_done}, 32'd0);
            check("rst_no_rdone", {31'd0, bus.dev_read_done}, 32'd0);
            @(posedge clk); #1;
        end
        foreach (addrs[i]) begin
            bus_rd(addrs[i], rv);
            check("post_rst_reg", rv, 32'd0);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mrav_timer.md
MRAV_TIMER -- requirements
Module: mrav_timer

Interface
REQ-001 The block SHALL have parameter MRAV_ADDR_WIDTH, default 32, the bus address width.
REQ-002 The block SHALL have parameter MRAV_DATA_WIDTH, default 32, the bus data and register width.
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h0000_1000, the address of register offset 0.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset; clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 The reset port SHALL be: rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port: dev_read  input  1  read request from the bus decoder, held until dev_read_done.
REQ-007 The block SHALL have port: dev_write  input  1  write request from the bus decoder, held until dev_write_done.
REQ-008 The block SHALL have port: dev_addr  input  MRAV_ADDR_WIDTH  full byte address.
REQ-009 The block SHALL have port: dev_cpu_data_out  input  MRAV_DATA_WIDTH  write data from the core.
REQ-010 The block SHALL have port: dev_cpu_data_in  output  MRAV_DATA_WIDTH  read data to the core.
REQ-011 The block SHALL have port: dev_read_done  output  1  one-cycle read completion pulse.
REQ-012 The block SHALL have port: dev_write_done  output  1  one-cycle write completion pulse.
REQ-013 The block SHALL have port: irq  output  1  level interrupt, high while STATUS.match=1 and CTRL.irq_en=1.

Function
REQ-014 Register offsets from BASE_ADDR SHALL be: 0x00 CTRL, 0x04 PRESCALE, 0x08 COMPARE, 0x0C COUNT, 0x10 STATUS; any other offset reads 0, and writes to it are ignored but still complete.
REQ-015 CTRL SHALL have bit0 enable, bit1 auto_reload and bit2 irq_en; all other bits read 0.
REQ-016 STATUS bit0 match SHALL be write-1-to-clear, and writing 0 SHALL have no effect.
REQ-017 The bus FSM SHALL have states IDLE and RESP; in IDLE, dev_read or dev_write moves it to RESP and latches the offset and write data.
REQ-018 If dev_read and dev_write are both high in IDLE, the write SHALL take priority and only dev_write_done SHALL pulse.
REQ-019 The register write SHALL commit on the IDLE->RESP edge; in RESP the matching done output SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE, giving a latency of 1 cycle from request to done.
REQ-020 Read data SHALL be sampled on the IDLE->RESP edge and held stable on dev_cpu_data_in during RESP; dev_cpu_data_in SHALL be 0 in IDLE.
REQ-021 A request still high in the IDLE cycle after RESP SHALL be treated as a new transaction.
REQ-022 When enable=1, a prescale counter SHALL increment each cycle; when it equals PRESCALE it SHALL reset to 0 and generate one tick, so a tick occurs every PRESCALE+1 cycles.
REQ-023 On a tick with COUNT==COMPARE, the block SHALL set STATUS.match; COUNT SHALL then become 0 if auto_reload=1, or COUNT+1 otherwise.
REQ-024 On a tick with COUNT!=COMPARE, COUNT SHALL increment modulo 2^MRAV_DATA_WIDTH, wrapping from all-ones to 0 without setting any flag.
REQ-025 When enable=0, the prescale counter and COUNT SHALL hold their values.
REQ-026 When enable goes from 0 to 1, the prescale counter SHALL be cleared.
REQ-027 Simultaneous events: a bus write to COUNT SHALL override the tick update in that cycle; a match set SHALL override a same-cycle W1C clear; a write to PRESCALE SHALL also clear the prescale counter.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL set CTRL, PRESCALE, COMPARE, COUNT, STATUS and the prescale counter to 0 and the FSM to IDLE.
REQ-029 While rst=1, the block SHALL drive dev_cpu_data_in=0, dev_read_done=0, dev_write_done=0 and irq=0.
REQ-030 Reset asserted during RESP SHALL abort the transaction with no done pulse, and a write already committed SHALL be overwritten by the reset values.

Verification
REQ-031 Bench scenario: write COMPARE=5, PRESCALE=0, CTRL=0x7 -> irq rises 6 ticks after enable with COUNT=0; W1C STATUS=1 -> irq=0 the next cycle.
REQ-032 Bench scenario: PRESCALE=3, CTRL=0x1 -> COUNT increments every 4 cycles; read COUNT returns a monotonically increasing value, with dev_read_done exactly 1 cycle after dev_read.
REQ-033 Bench scenario: COUNT=0xFFFF_FFFF, COMPARE=0, auto_reload=0, enable -> the next tick gives COUNT=0 and match=0; the following tick gives match=1 and COUNT=1.
REQ-034 Bench scenario: a write to COUNT=0x10 in the same cycle as a tick -> COUNT reads back 0x10.
REQ-035 Bench scenario: dev_read and dev_write high together at offset 0x08 -> COMPARE is updated, only dev_write_done pulses, and a read of offset 0x20 returns 0.
REQ-036 Bench scenario: rst asserted during RESP -> no done pulse occurs and all registers read 0 afterwards.
